// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause-22 MDIO master: FSM states, register
// offsets, opcode constants, register field positions and a byte-enable
// merge helper.
package mdio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_HDR,
    ST_TA,
    ST_DATA
  } mdio_state_e;

  // Byte offsets of the register words; the word select is bits [7:2].
  localparam logic [7:0] OFS_CTRL   = 8'h00;
  localparam logic [7:0] OFS_WDATA  = 8'h04;
  localparam logic [7:0] OFS_RDATA  = 8'h08;
  localparam logic [7:0] OFS_STATUS = 8'h0C;
  localparam logic [7:0] OFS_CLKDIV = 8'h10;

  // Clause-22 opcodes as they appear on the wire.
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  // CTRL fields.
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_OP_BIT     = 1;
  localparam int CTRL_PHYAD_LSB  = 8;
  localparam int CTRL_REGAD_LSB  = 16;
  localparam int CTRL_PRESUP_BIT = 31;

  // STATUS fields.
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  // Bits per frame section after the preamble.
  localparam int HDR_BITS  = 14;
  localparam int TA_BITS   = 2;
  localparam int DATA_BITS = 16;

  // Replace the bytes of old_val selected by be with those of wdata.
  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: divides mclk by 2*(div+1) while enabled. mdc is low for the
// first half of each bit and high for the second. rise_stb / fall_stb are
// high for the single mclk cycle whose closing edge raises / lowers mdc.
module mdio_clk_gen (
  input  logic       mclk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] div,
  output logic       mdc,
  output logic       rise_stb,
  output logic       fall_stb
);

  logic [7:0] cnt;
  logic       half_end;

  assign half_end = en && (cnt == div);
  assign rise_stb = half_end && !mdc;
  assign fall_stb = half_end && mdc;

  // Half-period counter and mdc toggle; idle holds mdc low with the counter cleared.
  always_ff @(posedge mclk or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (reset) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (half_end) begin
      cnt <= '0;
      mdc <= !mdc;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mdio_master.sv
// Register-programmed Clause-22 MDIO management master. One read or write
// frame per START: preamble, ST/OP/PHYAD/REGAD header, turnaround, 16 data
// bits. Optional build macro MDIO_PRE_SUPPRESS_EN implements CTRL[31]
// (preamble suppression); without it CTRL[31] reads 0 and ignores writes.
module mdio_master
  import mdio_pkg::*;
#(
  parameter logic [7:0] CLKDIV_RST = 8'd10,
  parameter int         PRE_LEN    = 32
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        reg_cs,
  input  logic        reg_wr,
  input  logic [7:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  input  logic [3:0]  reg_be,
  output logic [31:0] reg_rdata,
  output logic        reg_ack,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_out_en,
  input  logic        mdio_in,
  output logic        mdio_busy
);

  localparam logic [5:0] PRE_LAST  = 6'(PRE_LEN - 1);
  localparam logic [5:0] HDR_LAST  = 6'(HDR_BITS - 1);
  localparam logic [5:0] TA_LAST   = 6'(TA_BITS - 1);
  localparam logic [5:0] DATA_LAST = 6'(DATA_BITS - 1);

  // Register file.
  logic        op_q;          // 1 = read frame
  logic [4:0]  phyad_q;
  logic [4:0]  regad_q;
  logic        pre_sup_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic [7:0]  clkdiv_q;
  logic        done_q;

  // FSM state and datapath.
  mdio_state_e state, state_nxt;
  logic [5:0]  bit_cnt, bit_cnt_nxt;
  logic [31:0] tx_sr, tx_nxt;
  logic [15:0] rx_sr, rx_nxt;
  logic [15:0] rdata_nxt;
  logic        out_nxt, oe_nxt;
  logic        done_set;
  logic [1:0]  sync_q;
  logic        rise_stb, fall_stb;

  // Bus decode.
  logic        acc, wr_acc;
  logic        wr_ctrl, wr_wdata, wr_status, wr_clkdiv;
  logic [31:0] ctrl_rd, ctrl_new, wdata_new, clkdiv_new, rd_mux;
  logic        pre_sup_new, start_go;
  logic [31:0] frame_new;
  logic        unused_bits;

  assign mdio_busy = (state != ST_IDLE);

  assign acc       = reg_cs && !reg_ack;
  assign wr_acc    = acc && reg_wr;
  assign wr_ctrl   = wr_acc && (reg_addr[7:2] == OFS_CTRL[7:2]);
  assign wr_wdata  = wr_acc && (reg_addr[7:2] == OFS_WDATA[7:2]);
  assign wr_status = wr_acc && (reg_addr[7:2] == OFS_STATUS[7:2]);
  assign wr_clkdiv = wr_acc && (reg_addr[7:2] == OFS_CLKDIV[7:2]);

  assign ctrl_rd = {pre_sup_q, 10'b0, regad_q, 3'b0, phyad_q, 6'b0, op_q, 1'b0};
  assign ctrl_new   = apply_be(ctrl_rd, reg_wdata, reg_be);
  assign wdata_new  = apply_be({16'b0, wdata_q}, reg_wdata, reg_be);
  assign clkdiv_new = apply_be({24'b0, clkdiv_q}, reg_wdata, reg_be);

`ifdef MDIO_PRE_SUPPRESS_EN
  assign pre_sup_new = ctrl_new[CTRL_PRESUP_BIT];
`else
  assign pre_sup_new = 1'b0;
  assign pre_sup_q   = 1'b0;
`endif

  assign start_go = wr_ctrl && !mdio_busy && ctrl_new[CTRL_START_BIT];

  // Wire image of header, turnaround and data; read frames never drive TA/DATA.
  assign frame_new = {2'b01,
                      ctrl_new[CTRL_OP_BIT] ? OP_READ : OP_WRITE,
                      ctrl_new[CTRL_PHYAD_LSB +: 5],
                      ctrl_new[CTRL_REGAD_LSB +: 5],
                      ctrl_new[CTRL_OP_BIT] ? 2'b11 : 2'b10,
                      wdata_q};

  assign unused_bits = ^{reg_addr[1:0], ctrl_new, wdata_new[31:16], clkdiv_new[31:8]};

  mdio_clk_gen u_clk_gen (
    .mclk     (mclk),
    .reset    (reset),
    .en       (mdio_busy),
    .div      (clkdiv_q),
    .mdc      (mdc),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Read-data multiplexer; unmapped words read zero.
  always_comb begin
    rd_mux = '0;
    case (reg_addr[7:2])
      OFS_CTRL[7:2]:   rd_mux = ctrl_rd;
      OFS_WDATA[7:2]:  rd_mux = {16'b0, wdata_q};
      OFS_RDATA[7:2]:  rd_mux = {16'b0, rdata_q};
      OFS_STATUS[7:2]: rd_mux = {30'b0, done_q, mdio_busy};
      OFS_CLKDIV[7:2]: rd_mux = {24'b0, clkdiv_q};
      default:         rd_mux = '0;
    endcase
  end

  // Bus handshake and programmable registers; frame setup is frozen while busy.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      reg_ack   <= 1'b0;
      reg_rdata <= '0;
      op_q      <= 1'b0;
      phyad_q   <= '0;
      regad_q   <= '0;
      wdata_q   <= '0;
      clkdiv_q  <= CLKDIV_RST;
      done_q    <= 1'b0;
`ifdef MDIO_PRE_SUPPRESS_EN
      pre_sup_q <= 1'b0;
`endif
    end else begin
      reg_ack   <= acc;
      reg_rdata <= (acc && !reg_wr) ? rd_mux : '0;
      if (wr_ctrl && !mdio_busy) begin
        op_q    <= ctrl_new[CTRL_OP_BIT];
        phyad_q <= ctrl_new[CTRL_PHYAD_LSB +: 5];
        regad_q <= ctrl_new[CTRL_REGAD_LSB +: 5];
`ifdef MDIO_PRE_SUPPRESS_EN
        pre_sup_q <= ctrl_new[CTRL_PRESUP_BIT];
`endif
      end
      if (wr_wdata && !mdio_busy)  wdata_q  <= wdata_new[15:0];
      if (wr_clkdiv && !mdio_busy) clkdiv_q <= clkdiv_new[7:0];
      // Completion outranks a coincident write-1-to-clear.
      if (done_set)
        done_q <= 1'b1;
      else if (wr_status && reg_be[0] && reg_wdata[STATUS_DONE_BIT])
        done_q <= 1'b0;
    end
  end

  // Two-flop synchronizer for the asynchronous pad input.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], mdio_in};
  end

  // Frame sequencer: next state, serial shift registers and pad controls.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    tx_nxt      = tx_sr;
    rx_nxt      = rx_sr;
    rdata_nxt   = rdata_q;
    out_nxt     = mdio_out;
    oe_nxt      = mdio_out_en;
    done_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_go) begin
          bit_cnt_nxt = '0;
          oe_nxt      = 1'b1;
          rx_nxt      = '0;
          if (pre_sup_new) begin
            state_nxt = ST_HDR;
            out_nxt   = frame_new[31];
            tx_nxt    = {frame_new[30:0], 1'b0};
          end else begin
            state_nxt = ST_PRE;
            out_nxt   = 1'b1;
            tx_nxt    = frame_new;
          end
        end
      end
      ST_PRE: begin
        if (fall_stb) begin
          if (bit_cnt == PRE_LAST) begin
            state_nxt   = ST_HDR;
            bit_cnt_nxt = '0;
            out_nxt     = tx_sr[31];
            tx_nxt      = {tx_sr[30:0], 1'b0};
          end else begin
            bit_cnt_nxt = bit_cnt + 6'd1;
          end
        end
      end
      ST_HDR: begin
        if (fall_stb) begin
          out_nxt = tx_sr[31];
          tx_nxt  = {tx_sr[30:0], 1'b0};
          if (bit_cnt == HDR_LAST) begin
            state_nxt   = ST_TA;
            bit_cnt_nxt = '0;
            if (op_q) begin
              oe_nxt  = 1'b0;
              out_nxt = 1'b1;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 6'd1;
          end
        end
      end
      ST_TA: begin
        if (fall_stb) begin
          out_nxt = op_q ? 1'b1 : tx_sr[31];
          tx_nxt  = {tx_sr[30:0], 1'b0};
          if (bit_cnt == TA_LAST) begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + 6'd1;
          end
        end
      end
      ST_DATA: begin
        if (rise_stb && op_q) rx_nxt = {rx_sr[14:0], sync_q[1]};
        if (fall_stb) begin
          if (bit_cnt == DATA_LAST) begin
            state_nxt   = ST_IDLE;
            bit_cnt_nxt = '0;
            out_nxt     = 1'b1;
            oe_nxt      = 1'b0;
            done_set    = 1'b1;
            if (op_q) rdata_nxt = rx_sr;
          end else begin
            bit_cnt_nxt = bit_cnt + 6'd1;
            out_nxt     = op_q ? 1'b1 : tx_sr[31];
            tx_nxt      = {tx_sr[30:0], 1'b0};
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer registers; reset abandons a frame without touching RDATA's reset value.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      rdata_q     <= '0;
      mdio_out    <= 1'b1;
      mdio_out_en <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      tx_sr       <= tx_nxt;
      rx_sr       <= rx_nxt;
      rdata_q     <= rdata_nxt;
      mdio_out    <= out_nxt;
      mdio_out_en <= oe_nxt;
    end
  end

endmodule
